// File: rtl/param_sipo_receiver.sv
// param_sipo_receiver: serial-in/parallel-out word assembler with a one-entry valid/ready holding buffer
module param_sipo_receiver #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 clear,
    output logic [N-1:0]         data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic [$clog2(N)-1:0] bit_cnt,
    output logic                 overflow
);
    localparam int CW = $clog2(N);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          st_q, st_d;
    logic [N-1:0]    sh_q, sh_d, out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    word;
    logic            done, xfer;

    // shift-in of the current bit, completion and transfer detection, and next-state selection
    always_comb begin
        word  = MSB_FIRST ? {sh_q[N-2:0], bit_in} : {bit_in, sh_q[N-1:1]};
        done  = bit_valid && (cnt_q == CW'(N-1));
        xfer  = (st_q == FULL) && data_ready;
        sh_d  = bit_valid ? word : sh_q;
        cnt_d = bit_valid ? (done ? '0 : cnt_q + CW'(1)) : cnt_q;
        st_d  = st_q;
        out_d = out_q;
        ovf_d = ovf_q;
        case (st_q)
            EMPTY: if (done) begin
                out_d = word;
                st_d  = FULL;
            end
            FULL: begin
                if (xfer && done) out_d = word;
                else if (xfer) st_d = EMPTY;
                else if (done) ovf_d = 1'b1;
            end
            default: st_d = EMPTY;
        endcase
        if (clear) begin
            sh_d  = '0;
            cnt_d = '0;
            st_d  = EMPTY;
            out_d = '0;
            ovf_d = 1'b0;
        end
    end

    // state registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= EMPTY;
            sh_q  <= '0;
            out_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            sh_q  <= sh_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign data_out   = out_q;
    assign data_valid = (st_q == FULL);
    assign bit_cnt    = cnt_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_param_sipo_receiver.sv
// tb_param_sipo_receiver: directed checks of the SIPO receiver in both bit orders
module tb_param_sipo_receiver;
    logic       clk = 1'b0;
    logic       rst, bit_in, bit_valid, clear, data_ready;
    logic [7:0] m_out, l_out;
    logic       m_vld, l_vld, m_ovf, l_ovf;
    logic [2:0] m_cnt, l_cnt;
    int         n_chk = 0;
    int         n_pass = 0;

    param_sipo_receiver #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .data_out(m_out), .data_valid(m_vld), .data_ready(data_ready),
        .bit_cnt(m_cnt), .overflow(m_ovf)
    );

    param_sipo_receiver #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .data_out(l_out), .data_valid(l_vld), .data_ready(data_ready),
        .bit_cnt(l_cnt), .overflow(l_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out"}, m_out, 0);
        check({tag, "_vld"}, m_vld, 0);
        check({tag, "_cnt"}, m_cnt, 0);
        check({tag, "_ovf"}, m_ovf, 0);
    endtask

    initial begin
        logic [7:0] stream [3];
        logic [7:0] t;
        stream = '{8'h01, 8'h80, 8'hFF};
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; data_ready = 1'b1;
        #3;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // bits 1,0,1,1,0,0,1,0 back to back
        send_word(8'hB2);
        check("t1_msb_out", m_out, 8'hB2);
        check("t1_msb_vld", m_vld, 1);
        check("t1_cnt", m_cnt, 0);
        check("t1_ovf", m_ovf, 0);
        check("t1_lsb_out", l_out, 8'h4D);
        @(negedge clk);
        check("t1_vld_drop", m_vld, 0);

        // same stream with random gaps
        t = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            send_bit(t[i]);
            if (i != 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("t2_msb_out", m_out, 8'hB2);
        check("t2_lsb_out", l_out, 8'h4D);
        check("t2_lsb_vld", l_vld, 1);
        @(negedge clk);

        // back-pressure loses the second word
        data_ready = 1'b0;
        send_word(8'hA5);
        send_word(8'h3C);
        check("t3_out", m_out, 8'hA5);
        check("t3_vld", m_vld, 1);
        check("t3_ovf", m_ovf, 1);
        data_ready = 1'b1;
        @(negedge clk);
        check("t3_drain_vld", m_vld, 0);
        check("t3_drain_out", m_out, 8'hA5);
        check("t3_ovf_sticky", m_ovf, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("t3_clear");

        // drain coincides with completion of the next word
        data_ready = 1'b0;
        send_word(8'h11);
        check("t4_first", m_out, 8'h11);
        t = 8'h22;
        for (int i = 7; i >= 1; i--) send_bit(t[i]);
        check("t4_hold", m_out, 8'h11);
        data_ready = 1'b1;
        send_bit(t[0]);
        data_ready = 1'b0;
        check("t4_out", m_out, 8'h22);
        check("t4_vld", m_vld, 1);
        check("t4_ovf", m_ovf, 0);

        // async reset mid-word, between clock edges
        repeat (5) send_bit(1'b0);
        check("t5_cnt_pre", m_cnt, 5);
        check("t5_vld_pre", m_vld, 1);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_zero("t5_async");
        @(negedge clk);
        data_ready = 1'b1;
        send_word(8'hFF);
        check("t5_out", m_out, 8'hFF);
        check("t5_vld", m_vld, 1);
        check("t5_lsb_out", l_out, 8'hFF);

        // clear beats a qualified bit while FULL with overflow
        data_ready = 1'b0;
        send_word(8'h01);
        send_word(8'h02);
        check("t6_ovf_pre", m_ovf, 1);
        clear = 1'b1;
        send_bit(1'b1);
        clear = 1'b0;
        check_zero("t6_clear");

        // back-to-back words with data_ready high
        data_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            t = stream[w];
            for (int i = 7; i >= 0; i--) begin
                send_bit(t[i]);
                if (i == 7) check($sformatf("t6_gap%0d", w), m_vld, 0);
            end
            check($sformatf("t6_out%0d", w), m_out, stream[w]);
            check($sformatf("t6_vld%0d", w), m_vld, 1);
        end
        check("t6_ovf", m_ovf, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
